// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register for an address/instruction pair.
// Flush and reset both leave a NOP bubble on the outputs.
// A stall counter saturates and is not cleared by flush.
// Build option: define PIPE_STAGE_SKID_EN to add a one-entry skid buffer.
// With the skid buffer, readyOut is registered.
// Without it, readyOut is ~validOut | readyIn and the stage holds a single entry.
module pipe_stage_reg #(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_INS = 32'h00000013,
  parameter int                CNT_W   = 16
) (
  input  logic              clkIn,
  input  logic              resetn,
  input  logic              flush,
  input  logic              validIn,
  output logic              readyOut,
  input  logic [ADDR_W-1:0] AddrIn,
  input  logic [DATA_W-1:0] InsIn,
  output logic              validOut,
  input  logic              readyIn,
  output logic [ADDR_W-1:0] AddrOut,
  output logic [DATA_W-1:0] InsOut,
  output logic [CNT_W-1:0]  stallCnt
);

  // Output register
  logic              valid_reg, valid_next;
  logic [ADDR_W-1:0] addr_reg,  addr_next;
  logic [DATA_W-1:0] ins_reg,   ins_next;

  // Stall counter
  logic [CNT_W-1:0]  stall_reg, stall_next;

  // Handshakes for the coming edge
  logic              take;   // upstream entry accepted
  logic              give;   // held entry released downstream

  assign take = validIn & readyOut;
  assign give = valid_reg & readyIn;

  assign validOut = valid_reg;
  assign AddrOut  = addr_reg;
  assign InsOut   = ins_reg;
  assign stallCnt = stall_reg;

  // Count edges where a valid entry is blocked downstream; saturate at all-ones, flush freezes it
  always_comb begin
    stall_next = stall_reg;
    if (valid_reg && !readyIn && !flush && (stall_reg != {CNT_W{1'b1}})) begin
      stall_next = stall_reg + CNT_W'(1);
    end
  end

  // Stall counter register; only reset clears it
  always_ff @(posedge clkIn or negedge resetn) begin
    if (!resetn) begin
      stall_reg <= '0;
    end else begin
      stall_reg <= stall_next;
    end
  end

`ifdef PIPE_STAGE_SKID_EN

  // Skid entry catches an accept that arrives while the output is blocked
  logic              skid_valid_reg, skid_valid_next;
  logic [ADDR_W-1:0] skid_addr_reg,  skid_addr_next;
  logic [DATA_W-1:0] skid_ins_reg,   skid_ins_next;
  logic              ready_reg,      ready_next;

  // readyOut comes straight from a flop, so upstream timing does not depend on readyIn
  assign readyOut = ready_reg;

  // Next-state for the output and skid entries; flush wins over every handshake
  always_comb begin
    valid_next      = valid_reg;
    addr_next       = addr_reg;
    ins_next        = ins_reg;
    skid_valid_next = skid_valid_reg;
    skid_addr_next  = skid_addr_reg;
    skid_ins_next   = skid_ins_reg;
    if (flush) begin
      valid_next      = 1'b0;
      addr_next       = '0;
      ins_next        = NOP_INS;
      skid_valid_next = 1'b0;
    end else if (give) begin
      if (skid_valid_reg) begin
        // Drain the skid entry first; take is impossible while the skid is full.
        valid_next      = 1'b1;
        addr_next       = skid_addr_reg;
        ins_next        = skid_ins_reg;
        skid_valid_next = 1'b0;
      end else if (take) begin
        // Back-to-back transfer with no bubble
        valid_next = 1'b1;
        addr_next  = AddrIn;
        ins_next   = InsIn;
      end else begin
        valid_next = 1'b0;
      end
    end else if (take) begin
      if (valid_reg) begin
        // Output is blocked: park the new entry in the skid.
        skid_valid_next = 1'b1;
        skid_addr_next  = AddrIn;
        skid_ins_next   = InsIn;
      end else begin
        valid_next = 1'b1;
        addr_next  = AddrIn;
        ins_next   = InsIn;
      end
    end
    ready_next = ~skid_valid_next;
  end

  // Output and skid registers with asynchronous clear
  always_ff @(posedge clkIn or negedge resetn) begin
    if (!resetn) begin
      valid_reg      <= 1'b0;
      addr_reg       <= '0;
      ins_reg        <= NOP_INS;
      skid_valid_reg <= 1'b0;
      skid_addr_reg  <= '0;
      skid_ins_reg   <= '0;
      ready_reg      <= 1'b1;
    end else begin
      valid_reg      <= valid_next;
      addr_reg       <= addr_next;
      ins_reg        <= ins_next;
      skid_valid_reg <= skid_valid_next;
      skid_addr_reg  <= skid_addr_next;
      skid_ins_reg   <= skid_ins_next;
      ready_reg      <= ready_next;
    end
  end

`else

  // Single-entry stage: room exists when empty or when the held entry leaves this edge
  assign readyOut = ~valid_reg | readyIn;

  // Next-state for the output entry; flush wins over every handshake
  always_comb begin
    valid_next = valid_reg;
    addr_next  = addr_reg;
    ins_next   = ins_reg;
    if (flush) begin
      valid_next = 1'b0;
      addr_next  = '0;
      ins_next   = NOP_INS;
    end else if (take) begin
      // Covers accept-into-empty and accept-with-release alike
      valid_next = 1'b1;
      addr_next  = AddrIn;
      ins_next   = InsIn;
    end else if (give) begin
      // Data is left in place so the outputs only move on a real load.
      valid_next = 1'b0;
    end
  end

  // Output register with asynchronous clear
  always_ff @(posedge clkIn or negedge resetn) begin
    if (!resetn) begin
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      ins_reg   <= NOP_INS;
    end else begin
      valid_reg <= valid_next;
      addr_reg  <= addr_next;
      ins_reg   <= ins_next;
    end
  end

`endif

endmodule
